// File: rtl/wb_queue_if.sv
// Bus bundle for the write-back queue: request channel, flush/stall controls,
// register-file write port, forwarding lookups and occupancy/pending status.
interface wb_queue_if #(
  parameter int WIDTH = 32,
  parameter int REGNO = 32,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(REGNO);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             flush;
  logic             rf_stall;
  logic             rf_we;
  logic [WIDTH-1:0] rf_w_addr;
  logic [WIDTH-1:0] rf_in;
  logic [AW-1:0]    q1_addr;
  logic [AW-1:0]    q2_addr;
  logic             q1_hit;
  logic             q2_hit;
  logic [WIDTH-1:0] q1_data;
  logic [WIDTH-1:0] q2_data;
  logic [REGNO-1:0] pending;
  logic [CW-1:0]    count;

  // Producer side: issues write-backs, controls flush/stall, performs lookups.
  modport master (
    output req_valid, req_addr, req_data, flush, rf_stall, q1_addr, q2_addr,
    input  req_ready, rf_we, rf_w_addr, rf_in, q1_hit, q2_hit, q1_data, q2_data,
           pending, count
  );

  // Queue side.
  modport slave (
    input  req_valid, req_addr, req_data, flush, rf_stall, q1_addr, q2_addr,
    output req_ready, rf_we, rf_w_addr, rf_in, q1_hit, q2_hit, q1_data, q2_data,
           pending, count
  );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue: circular FIFO of {addr, data} entries that drains into a
// register-file write port one entry per cycle, with forwarding lookups and a
// per-register pending mask. Writes to x0 are accepted and dropped.
module wb_queue #(
  parameter int WIDTH = 32,
  parameter int REGNO = 32,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_queue_if.slave   bus
);
  localparam int AW = $clog2(REGNO);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    mem_addr_q [DEPTH];
  logic [WIDTH-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             push;
  logic             pop;
  logic [PW-1:0]    idx;
  logic             q1_hit, q2_hit;
  logic [WIDTH-1:0] q1_data, q2_data;
  logic [REGNO-1:0] pending;

  // Handshake and drain decisions; flush suppresses both push and pop.
  assign full          = (count_q == CW'(DEPTH));
  assign bus.req_ready = !full && !bus.flush;
  assign push          = bus.req_valid && bus.req_ready && (bus.req_addr != '0);
  assign pop           = (count_q != '0) && !bus.rf_stall && !bus.flush;

  // Register-file port presents the head entry only while writing, else zeros.
  assign bus.rf_we     = pop;
  assign bus.rf_w_addr = pop ? WIDTH'(mem_addr_q[head_q]) : '0;
  assign bus.rf_in     = pop ? mem_data_q[head_q] : '0;
  assign bus.count     = count_q;
  assign bus.q1_hit    = q1_hit;
  assign bus.q2_hit    = q2_hit;
  assign bus.q1_data   = q1_data;
  assign bus.q2_data   = q2_data;
  assign bus.pending   = pending;

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  // Control state: reset asynchronously, everything else on posedge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage write at the tail.
  // NOTE: storage is deliberately not reset; validity comes solely from head/count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[tail_q] <= bus.req_addr;
      mem_data_q[tail_q] <= bus.req_data;
    end
  end

  // Lookups and pending mask over valid entries, scanned oldest to youngest so
  // the last match (closest to the tail) wins.
  always_comb begin
    q1_hit  = 1'b0;
    q2_hit  = 1'b0;
    q1_data = '0;
    q2_data = '0;
    pending = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        pending[mem_addr_q[idx]] = 1'b1;
        if ((bus.q1_addr != '0) && (mem_addr_q[idx] == bus.q1_addr)) begin
          q1_hit  = 1'b1;
          q1_data = mem_data_q[idx];
        end
        if ((bus.q2_addr != '0) && (mem_addr_q[idx] == bus.q2_addr)) begin
          q2_hit  = 1'b1;
          q2_data = mem_data_q[idx];
        end
      end
    end
    pending[0] = 1'b0;
  end
endmodule
